// File: rtl/cga_pkg.sv
// cga_pkg: shared FSM encoding, default decode bases and VRAM address width
// for the CGA ISA front end.
package cga_pkg;

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        REQ       = 2'd1,
        WAIT_DATA = 2'd2,
        DONE      = 2'd3
    } isa_state_e;

    localparam logic [19:0] MEM_BASE_DEF = 20'hB8000;
    localparam logic [9:0]  IO_BASE_DEF  = 10'h3D0;
    localparam int          VRAM_AW      = 14;

endpackage

// File: rtl/isa_strobe_sync.sv
// isa_strobe_sync: STAGES-deep synchroniser for one active-low ISA strobe,
// with a single-cycle pulse on the falling edge of the synchronised level.
module isa_strobe_sync #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic strobe_l_i,
    output logic level_o,
    output logic fall_o
);

    logic [STAGES-1:0] sync_q;
    logic              prev_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '1;
            prev_q <= 1'b1;
        end else begin
            sync_q <= {sync_q[STAGES-2:0], strobe_l_i};
            prev_q <= sync_q[STAGES-1];
        end
    end

    assign level_o = sync_q[STAGES-1];
    assign fall_o  = prev_q & ~sync_q[STAGES-1];

endmodule

// File: rtl/cga_isa_slave.sv
// cga_isa_slave: ISA bus front end of the CGA card (VRAM window + 3Dx I/O).
// Define WAIT_TIMEOUT_EN to bound VRAM wait states to TIMEOUT_CYCLES.
module cga_isa_slave
    import cga_pkg::*;
#(
    parameter logic [19:0] MEM_BASE       = MEM_BASE_DEF,
    parameter logic [9:0]  IO_BASE        = IO_BASE_DEF,
    parameter int          SYNC_STAGES    = 2,
    parameter int          TIMEOUT_CYCLES = 31
) (
    input  logic               clk,
    input  logic               reset_l,
    input  logic [19:0]        bus_a,
    input  logic               bus_aen,
    input  logic               bus_ior_l,
    input  logic               bus_iow_l,
    input  logic               bus_memr_l,
    input  logic               bus_memw_l,
    input  logic [7:0]         bus_d_in,
    output logic [7:0]         bus_d_out,
    output logic               bus_d_oe,
    output logic               bus_rdy,
    output logic               vram_req,
    output logic               vram_we,
    output logic [VRAM_AW-1:0] vram_addr,
    output logic [7:0]         vram_wdata,
    input  logic               vram_grant,
    input  logic [7:0]         vram_rdata,
    output logic               io_wr,
    output logic               io_rd,
    output logic [3:0]         io_addr,
    output logic [7:0]         io_wdata,
    input  logic [7:0]         io_rdata
);

`ifdef WAIT_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int TW = $clog2(TIMEOUT_CYCLES + 1);

    // strobe index: 0 ior, 1 iow, 2 memr, 3 memw
    logic [3:0] strb_l, lvl, fall;
    assign strb_l = {bus_memw_l, bus_memr_l, bus_iow_l, bus_ior_l};

    for (genvar g = 0; g < 4; g++) begin : g_sync
        isa_strobe_sync #(.STAGES(SYNC_STAGES)) u_sync (
            .clk        (clk),
            .rst_n      (reset_l),
            .strobe_l_i (strb_l[g]),
            .level_o    (lvl[g]),
            .fall_o     (fall[g])
        );
    end

    isa_state_e         state_q, state_d;
    logic [VRAM_AW-1:0] addr_q, addr_d;
    logic               we_q, we_d;
    logic [7:0]         wdata_q, wdata_d, rdata_q, rdata_d;
    logic               io_wr_q, io_wr_d, io_rd_q, io_rd_d;
    logic [3:0]         io_addr_q, io_addr_d;
    logic [7:0]         io_wdata_q, io_wdata_d;
    logic [TW-1:0]      tmo_q, tmo_d;

    logic mem_hit, io_hit, mem_start, mem_up, tmo_hit;
    assign mem_hit   = bus_a[19:14] == MEM_BASE[19:14];
    assign io_hit    = !bus_aen && bus_a[9:4] == IO_BASE[9:4];
    assign mem_start = (fall[2] | fall[3]) & mem_hit;
    assign mem_up    = we_q ? lvl[3] : lvl[2];
    assign tmo_hit   = TMO_EN && tmo_q == TW'(TIMEOUT_CYCLES - 1);

    always_comb begin
        state_d    = state_q;
        addr_d     = addr_q;
        we_d       = we_q;
        wdata_d    = wdata_q;
        rdata_d    = rdata_q;
        io_wr_d    = 1'b0;
        io_rd_d    = io_rd_q & ~lvl[0];
        io_addr_d  = io_addr_q;
        io_wdata_d = io_wdata_q;
        tmo_d      = '0;
        unique case (state_q)
            IDLE: begin
                if (mem_start) begin
                    addr_d  = bus_a[VRAM_AW-1:0];
                    we_d    = fall[3];
                    wdata_d = bus_d_in;
                    state_d = REQ;
                end else if (fall[1] && io_hit) begin
                    io_wr_d    = 1'b1;
                    io_addr_d  = bus_a[3:0];
                    io_wdata_d = bus_d_in;
                // an I/O read overlapping an I/O write is malformed; keep the pad off
                end else if (fall[0] && lvl[1] && io_hit) begin
                    io_rd_d   = 1'b1;
                    io_addr_d = bus_a[3:0];
                end
            end
            REQ: begin
                tmo_d = tmo_q + TW'(1);
                if (vram_grant) begin
                    state_d = we_q ? DONE : WAIT_DATA;
                end else if (mem_up) begin
                    state_d = IDLE;
                end else if (tmo_hit) begin
                    state_d = DONE;
                    rdata_d = 8'hFF;
                end
            end
            WAIT_DATA: begin
                rdata_d = vram_rdata;
                state_d = DONE;
            end
            DONE: state_d = mem_up ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset_l) begin
        if (!reset_l) begin
            state_q    <= IDLE;
            addr_q     <= '0;
            we_q       <= 1'b0;
            wdata_q    <= '0;
            rdata_q    <= '0;
            io_wr_q    <= 1'b0;
            io_rd_q    <= 1'b0;
            io_addr_q  <= '0;
            io_wdata_q <= '0;
            tmo_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            we_q       <= we_d;
            wdata_q    <= wdata_d;
            rdata_q    <= rdata_d;
            io_wr_q    <= io_wr_d;
            io_rd_q    <= io_rd_d;
            io_addr_q  <= io_addr_d;
            io_wdata_q <= io_wdata_d;
            tmo_q      <= tmo_d;
        end
    end

    assign vram_req   = state_q == REQ;
    assign bus_rdy    = !(state_q == REQ || state_q == WAIT_DATA);
    assign bus_d_oe   = io_rd_q | (state_q == DONE && !we_q && !lvl[2]);
    assign bus_d_out  = io_rd_q ? io_rdata : rdata_q;
    assign vram_we    = we_q;
    assign vram_addr  = addr_q;
    assign vram_wdata = wdata_q;
    assign io_wr      = io_wr_q;
    assign io_rd      = io_rd_q;
    assign io_addr    = io_addr_q;
    assign io_wdata   = io_wdata_q;

endmodule

// File: tb/tb_cga_isa_slave.sv
// tb_cga_isa_slave: randomized ISA cycles against a byte-array VRAM reference.
module tb_cga_isa_slave;

    logic        clk = 1'b0, reset_l = 1'b0;
    logic [19:0] bus_a = '0;
    logic        bus_aen = 1'b0;
    logic        bus_ior_l = 1'b1, bus_iow_l = 1'b1, bus_memr_l = 1'b1, bus_memw_l = 1'b1;
    logic [7:0]  bus_d_in = '0, bus_d_out;
    logic        bus_d_oe, bus_rdy, vram_req, vram_we, vram_grant = 1'b0;
    logic [13:0] vram_addr;
    logic [7:0]  vram_wdata, vram_rdata = '0;
    logic        io_wr, io_rd;
    logic [3:0]  io_addr;
    logic [7:0]  io_wdata, io_rdata = '0;

    int vectors = 0, miscompares = 0;
    logic [7:0] vram [16384];
    logic [7:0] ref_mem [16384];

    always #5 clk = ~clk;

    cga_isa_slave dut (
        .clk(clk), .reset_l(reset_l), .bus_a(bus_a), .bus_aen(bus_aen),
        .bus_ior_l(bus_ior_l), .bus_iow_l(bus_iow_l), .bus_memr_l(bus_memr_l), .bus_memw_l(bus_memw_l),
        .bus_d_in(bus_d_in), .bus_d_out(bus_d_out), .bus_d_oe(bus_d_oe), .bus_rdy(bus_rdy),
        .vram_req(vram_req), .vram_we(vram_we), .vram_addr(vram_addr), .vram_wdata(vram_wdata),
        .vram_grant(vram_grant), .vram_rdata(vram_rdata),
        .io_wr(io_wr), .io_rd(io_rd), .io_addr(io_addr), .io_wdata(io_wdata), .io_rdata(io_rdata)
    );

    // the VRAM sequencer commits a CPU write in its granted slot
    always @(posedge clk) if (vram_grant && vram_we) vram[vram_addr] <= vram_wdata;

    task automatic test_reset();
        repeat (2) @(negedge clk);
        vectors++; if (bus_rdy !== 1'b1) begin miscompares++; $display("FAIL rst_rdy: got %b want 1", bus_rdy); end
        vectors++; if (bus_d_oe !== 1'b0) begin miscompares++; $display("FAIL rst_oe: got %b want 0", bus_d_oe); end
        vectors++; if (bus_d_out !== 8'h00) begin miscompares++; $display("FAIL rst_dout: got %h want 00", bus_d_out); end
        vectors++; if ({vram_req, vram_we} !== 2'b00) begin miscompares++; $display("FAIL rst_req_we: got %b want 00", {vram_req, vram_we}); end
        vectors++; if ({vram_addr, vram_wdata} !== 22'h0) begin miscompares++; $display("FAIL rst_vram: got %h want 0", {vram_addr, vram_wdata}); end
        vectors++; if ({io_wr, io_rd, io_addr, io_wdata} !== 14'h0) begin miscompares++; $display("FAIL rst_io: got %h want 0", {io_wr, io_rd, io_addr, io_wdata}); end
        reset_l = 1'b1;
        repeat (2) @(negedge clk);
    endtask

    task automatic mem_write(input logic [13:0] a, input logic [7:0] d, input int dly);
        @(negedge clk);
        bus_a = 20'hB8000 | {6'b0, a}; bus_d_in = d; bus_memw_l = 1'b0;
        for (int i = 0; i < 10 && !vram_req; i++) @(negedge clk);
        vectors++; if (vram_req !== 1'b1 || bus_rdy !== 1'b0) begin miscompares++; $display("FAIL wr_req: req/rdy got %b%b want 10", vram_req, bus_rdy); end
        vectors++; if (vram_we !== 1'b1) begin miscompares++; $display("FAIL wr_we: got %b want 1", vram_we); end
        vectors++; if (vram_addr !== a) begin miscompares++; $display("FAIL wr_addr: got %h want %h", vram_addr, a); end
        vectors++; if (vram_wdata !== d) begin miscompares++; $display("FAIL wr_data: got %h want %h", vram_wdata, d); end
        repeat (dly) begin
            @(negedge clk);
            vectors++; if (vram_req !== 1'b1 || bus_rdy !== 1'b0) begin miscompares++; $display("FAIL wr_hold: req/rdy got %b%b want 10", vram_req, bus_rdy); end
        end
        vram_grant = 1'b1;
        @(negedge clk);
        vram_grant = 1'b0;
        for (int i = 0; i < 5 && !bus_rdy; i++) @(negedge clk);
        vectors++; if (bus_rdy !== 1'b1 || vram_req !== 1'b0 || bus_d_oe !== 1'b0) begin miscompares++; $display("FAIL wr_done: rdy/req/oe got %b%b%b want 100", bus_rdy, vram_req, bus_d_oe); end
        bus_memw_l = 1'b1;
        ref_mem[a] = d;
        repeat (4) @(negedge clk);
    endtask

    task automatic mem_read(input logic [13:0] a, input int dly);
        @(negedge clk);
        bus_a = 20'hB8000 | {6'b0, a}; bus_memr_l = 1'b0;
        for (int i = 0; i < 10 && !vram_req; i++) @(negedge clk);
        vectors++; if (vram_req !== 1'b1 || vram_we !== 1'b0 || vram_addr !== a) begin miscompares++; $display("FAIL rd_req: req/we/addr got %b%b %h want 10 %h", vram_req, vram_we, vram_addr, a); end
        repeat (dly) begin
            @(negedge clk);
            vectors++; if (bus_rdy !== 1'b0 || bus_d_oe !== 1'b0) begin miscompares++; $display("FAIL rd_hold: rdy/oe got %b%b want 00", bus_rdy, bus_d_oe); end
        end
        vram_grant = 1'b1; vram_rdata = 8'($urandom);
        @(negedge clk);
        vram_grant = 1'b0; vram_rdata = vram[vram_addr];
        @(negedge clk);
        vram_rdata = 8'($urandom);
        for (int i = 0; i < 5 && !bus_rdy; i++) @(negedge clk);
        vectors++; if (bus_rdy !== 1'b1 || bus_d_oe !== 1'b1) begin miscompares++; $display("FAIL rd_ready: rdy/oe got %b%b want 11", bus_rdy, bus_d_oe); end
        vectors++; if (bus_d_out !== ref_mem[a]) begin miscompares++; $display("FAIL rd_data: got %h want %h", bus_d_out, ref_mem[a]); end
        bus_memr_l = 1'b1;
        for (int i = 0; i < 6 && bus_d_oe; i++) @(negedge clk);
        vectors++; if (bus_d_oe !== 1'b0) begin miscompares++; $display("FAIL rd_release: oe got %b want 0", bus_d_oe); end
        repeat (2) @(negedge clk);
    endtask

    task automatic test_plan_mem();
        mem_write(14'h0055, 8'hAA, 5);
        mem_read(14'h0055, 2);
        vram[14'h0003] = 8'h11; ref_mem[14'h0003] = 8'h11;
        mem_read(14'h0003, 0);
        mem_write(14'h3FFF, 8'h5C, 0);
        mem_read(14'h3FFF, 3);
    endtask

    task automatic test_io_write();
        logic [3:0] exp_a;
        logic [7:0] exp_d, d;
        int pulses;
        logic rdy_low;
        exp_a = '0; exp_d = '0;
        for (int aen = 0; aen < 2; aen++) begin
            for (int k = 0; k < 2; k++) begin
                d = (k == 0) ? 8'h01 : 8'h05;
                @(negedge clk);
                bus_aen = aen[0]; bus_a = 20'h003D4 + 20'(k); bus_d_in = d; bus_iow_l = 1'b0;
                pulses = 0; rdy_low = 1'b0;
                repeat (8) begin
                    @(negedge clk);
                    if (io_wr) pulses++;
                    if (!bus_rdy) rdy_low = 1'b1;
                end
                if (aen == 0) begin exp_a = 4'(4 + k); exp_d = d; end
                vectors++; if (pulses != (aen == 0 ? 1 : 0)) begin miscompares++; $display("FAIL iow_pulses aen=%0d: got %0d want %0d", aen, pulses, aen == 0 ? 1 : 0); end
                vectors++; if (rdy_low !== 1'b0) begin miscompares++; $display("FAIL iow_rdy: rdy went low"); end
                vectors++; if (io_addr !== exp_a || io_wdata !== exp_d) begin miscompares++; $display("FAIL iow_latch: got %h/%h want %h/%h", io_addr, io_wdata, exp_a, exp_d); end
                bus_iow_l = 1'b1; bus_aen = 1'b0;
                repeat (4) @(negedge clk);
            end
        end
    endtask

    task automatic test_io_read();
        logic [3:0] r;
        for (int k = 0; k < 3; k++) begin
            r = 4'($urandom);
            @(negedge clk);
            bus_a = 20'h003D0 | {16'b0, r}; io_rdata = 8'($urandom); bus_ior_l = 1'b0;
            for (int i = 0; i < 8 && !io_rd; i++) @(negedge clk);
            vectors++; if (io_rd !== 1'b1 || bus_d_oe !== 1'b1 || bus_rdy !== 1'b1) begin miscompares++; $display("FAIL ior_active: rd/oe/rdy got %b%b%b want 111", io_rd, bus_d_oe, bus_rdy); end
            vectors++; if (io_addr !== r) begin miscompares++; $display("FAIL ior_addr: got %h want %h", io_addr, r); end
            io_rdata = 8'($urandom);
            #1;
            vectors++; if (bus_d_out !== io_rdata) begin miscompares++; $display("FAIL ior_data: got %h want %h", bus_d_out, io_rdata); end
            bus_ior_l = 1'b1;
            for (int i = 0; i < 6 && io_rd; i++) @(negedge clk);
            vectors++; if (io_rd !== 1'b0 || bus_d_oe !== 1'b0) begin miscompares++; $display("FAIL ior_release: rd/oe got %b%b want 00", io_rd, bus_d_oe); end
        end
    endtask

    task automatic test_undecoded();
        logic bad;
        for (int k = 0; k < 4; k++) begin
            @(negedge clk);
            bus_a = (k < 2) ? 20'hB0000 : 20'h003B4;
            bus_d_in = 8'h77;
            case (k)
                0: bus_memw_l = 1'b0;
                1: bus_memr_l = 1'b0;
                2: bus_iow_l = 1'b0;
                default: bus_ior_l = 1'b0;
            endcase
            bad = 1'b0;
            repeat (8) begin
                @(negedge clk);
                if (vram_req || io_wr || io_rd || bus_d_oe || !bus_rdy) bad = 1'b1;
            end
            vectors++; if (bad !== 1'b0) begin miscompares++; $display("FAIL undecoded_%0d: outputs reacted", k); end
            {bus_memw_l, bus_memr_l, bus_iow_l, bus_ior_l} = 4'hF;
            repeat (4) @(negedge clk);
        end
    endtask

    task automatic test_simultaneous();
        int pulses;
        @(negedge clk);
        bus_a = 20'hBB3D4; bus_d_in = 8'h3C; bus_memw_l = 1'b0; bus_iow_l = 1'b0;
        pulses = 0;
        for (int i = 0; i < 10 && !vram_req; i++) begin @(negedge clk); if (io_wr) pulses++; end
        vectors++; if (vram_req !== 1'b1 || pulses != 0) begin miscompares++; $display("FAIL simul: req %b io_wr pulses %0d want 1/0", vram_req, pulses); end
        vram_grant = 1'b1;
        @(negedge clk);
        vram_grant = 1'b0;
        repeat (4) begin @(negedge clk); if (io_wr) pulses++; end
        vectors++; if (pulses != 0 || bus_rdy !== 1'b1) begin miscompares++; $display("FAIL simul_done: pulses %0d rdy %b want 0/1", pulses, bus_rdy); end
        ref_mem[14'h33D4] = 8'h3C;
        bus_memw_l = 1'b1; bus_iow_l = 1'b1;
        repeat (4) @(negedge clk);
        mem_read(14'h33D4, 1);
    endtask

    task automatic test_abort();
        @(negedge clk);
        bus_a = 20'hB8200; bus_d_in = 8'hE1; bus_memw_l = 1'b0;
        for (int i = 0; i < 10 && !vram_req; i++) @(negedge clk);
        bus_memw_l = 1'b1;
        for (int i = 0; i < 8 && vram_req; i++) @(negedge clk);
        vectors++; if (vram_req !== 1'b0 || bus_rdy !== 1'b1) begin miscompares++; $display("FAIL abort: req/rdy got %b%b want 01", vram_req, bus_rdy); end
        repeat (3) @(negedge clk);
        mem_read(14'h0200, 0);
        @(negedge clk);
        bus_a = 20'hB8201; bus_d_in = 8'h9D; bus_memw_l = 1'b0;
        for (int i = 0; i < 10 && !vram_req; i++) @(negedge clk);
        bus_memw_l = 1'b1; vram_grant = 1'b1;
        @(negedge clk);
        vram_grant = 1'b0;
        ref_mem[14'h0201] = 8'h9D;
        repeat (6) @(negedge clk);
        mem_read(14'h0201, 0);
    endtask

    task automatic test_reset_mid();
        @(negedge clk);
        bus_a = 20'hB8300; bus_d_in = 8'h42; bus_memw_l = 1'b0;
        for (int i = 0; i < 10 && !vram_req; i++) @(negedge clk);
        reset_l = 1'b0;
        #1;
        vectors++; if (bus_rdy !== 1'b1 || vram_req !== 1'b0) begin miscompares++; $display("FAIL reset_mid: rdy/req got %b%b want 10", bus_rdy, vram_req); end
        bus_memw_l = 1'b1;
        @(negedge clk);
        reset_l = 1'b1;
        repeat (2) @(negedge clk);
        mem_write(14'h0300, 8'h24, 2);
        mem_read(14'h0300, 1);
    endtask

    task automatic test_wait_limit();
        int n;
        @(negedge clk);
        bus_a = 20'hB8123; bus_memr_l = 1'b0;
        for (int i = 0; i < 10 && !vram_req; i++) @(negedge clk);
        n = 0;
        while (!bus_rdy && n < 60) begin n++; @(negedge clk); end
`ifdef WAIT_TIMEOUT_EN
        vectors++; if (n != 31) begin miscompares++; $display("FAIL timeout_len: got %0d want 31", n); end
        vectors++; if (bus_d_out !== 8'hFF || bus_d_oe !== 1'b1 || vram_req !== 1'b0) begin miscompares++; $display("FAIL timeout_data: dout %h oe %b req %b want FF 1 0", bus_d_out, bus_d_oe, vram_req); end
`else
        vectors++; if (n != 60 || vram_req !== 1'b1) begin miscompares++; $display("FAIL unbounded_wait: rdy after %0d req %b want 60 1", n, vram_req); end
        vram_grant = 1'b1;
        @(negedge clk);
        vram_grant = 1'b0; vram_rdata = vram[vram_addr];
        @(negedge clk);
        vram_rdata = 8'($urandom);
        for (int i = 0; i < 5 && !bus_rdy; i++) @(negedge clk);
        vectors++; if (bus_d_out !== ref_mem[14'h0123]) begin miscompares++; $display("FAIL unbounded_data: got %h want %h", bus_d_out, ref_mem[14'h0123]); end
`endif
        bus_memr_l = 1'b1;
        repeat (6) @(negedge clk);
    endtask

    task automatic test_random();
        logic [13:0] a;
        for (int k = 0; k < 24; k++) begin
            a = ($urandom_range(0, 1) != 0) ? 14'h0100 + 14'($urandom_range(0, 7)) : 14'($urandom);
            if ($urandom_range(0, 1) != 0) mem_write(a, 8'($urandom), int'($urandom_range(0, 6)));
            else mem_read(a, int'($urandom_range(0, 6)));
        end
    endtask

    initial begin
        for (int i = 0; i < 16384; i++) begin
            vram[i] = 8'($urandom);
            ref_mem[i] = vram[i];
        end
        test_reset();
        test_plan_mem();
        test_io_write();
        test_io_read();
        test_undecoded();
        test_simultaneous();
        test_abort();
        test_reset_mid();
        test_wait_limit();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
